// File: rtl/register_file_pkg.sv
// Shared CPU-core constants used to size the general register file.
package register_file_pkg;

    localparam int WORD_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 3;

endpackage

// File: rtl/register_file.sv
// Two-read, one-write general register file with asynchronous clear.
// Reads are combinational from the stored array; writes land on the rising edge.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (write) begin
            regs_d[rd_addr] = data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read straight from the flops: a write in flight is not forwarded.
    assign rs_data = regs_q[rs_addr];
    assign rt_data = regs_q[rt_addr];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus queues expected read values,
// a separate monitor samples both read ports and scores them.
module tb_register_file;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clock;
    logic          reset_n;
    logic          write;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;

    typedef struct {
        string         name;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
    } exp_t;

    exp_t exp_q[$];
    int   chk_seq = 0;
    int   total   = 0;
    int   bad     = 0;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .write   (write),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rd_addr (rd_addr),
        .data    (data),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Queue an expectation and signal the monitor; inputs stay stable meanwhile.
    task automatic expect_rd(input string name, input logic [DW-1:0] e_rs, input logic [DW-1:0] e_rt);
        exp_t e;
        e.name = name;
        e.rs   = e_rs;
        e.rt   = e_rt;
        exp_q.push_back(e);
        chk_seq++;
        #2;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        write   = 1'b1;
        rd_addr = a;
        data    = d;
        @(posedge clock);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk_seq);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow: no expectation queued");
            end else begin
                e = exp_q.pop_front();
                total++;
                if (rs_data !== e.rs || rt_data !== e.rt) begin
                    bad++;
                    $display("FAIL %s: got rs=%h rt=%h, want rs=%h rt=%h",
                             e.name, rs_data, rt_data, e.rs, e.rt);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset_n = 1'b0;
        write   = 1'b0;
        rs_addr = '0;
        rt_addr = '0;
        rd_addr = '0;
        data    = '0;

        // Reset state, both ports across every address.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            rs_addr = AW'(i);
            rt_addr = AW'(7 - i);
            expect_rd($sformatf("reset_read_%0d", i), 16'h0000, 16'h0000);
        end

        @(negedge clock);
        reset_n = 1'b1;

        // Basic writes to the first and last register.
        wr(3'd0, 16'h0001);
        wr(3'd7, 16'h00AB);
        @(negedge clock);
        write   = 1'b0;
        rs_addr = 3'd0;
        rt_addr = 3'd7;
        expect_rd("write_0_and_7", 16'h0001, 16'h00AB);

        // Write disabled: no change over several edges.
        write   = 1'b0;
        rd_addr = 3'd3;
        data    = 16'hFFFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rs_addr = 3'd3;
        rt_addr = 3'd3;
        expect_rd("no_write_when_disabled", 16'h0000, 16'h0000);

        // Read-during-write: old value before the edge, new after.
        @(negedge clock);
        rs_addr = 3'd5;
        rt_addr = 3'd5;
        rd_addr = 3'd5;
        data    = 16'h1234;
        write   = 1'b1;
        expect_rd("rdw_before_edge", 16'h0000, 16'h0000);
        @(posedge clock);
        #1;
        expect_rd("rdw_after_edge", 16'h1234, 16'h1234);

        // Fill all registers, then sweep for aliasing.
        for (int i = 0; i < 8; i++) wr(AW'(i), 16'h1000 + DW'(i));
        @(negedge clock);
        write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            rs_addr = AW'(i);
            rt_addr = AW'((i + 3) % 8);
            expect_rd($sformatf("fill_sweep_%0d", i),
                      16'h1000 + DW'(i), 16'h1000 + DW'((i + 3) % 8));
        end

        // Asynchronous reset between edges clears immediately.
        wr(3'd2, 16'hBEEF);
        @(negedge clock);
        write   = 1'b0;
        rs_addr = 3'd2;
        rt_addr = 3'd5;
        expect_rd("beef_written", 16'hBEEF, 16'h1005);
        reset_n = 1'b0;
        expect_rd("async_reset_clears", 16'h0000, 16'h0000);

        // Writes are ignored while reset is held across an edge.
        write   = 1'b1;
        rd_addr = 3'd4;
        data    = 16'hAAAA;
        @(posedge clock);
        #1;
        rs_addr = 3'd4;
        rt_addr = 3'd4;
        expect_rd("write_ignored_in_reset", 16'h0000, 16'h0000);

        // First edge after release performs a normal write.
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        expect_rd("first_write_after_reset", 16'hAAAA, 16'hAAAA);
        @(negedge clock);
        write   = 1'b0;
        rs_addr = 3'd2;
        rt_addr = 3'd7;
        expect_rd("others_stay_cleared", 16'h0000, 16'h0000);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
